// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  // Default geometry: 16 registers of 64 bits.
  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 4;
  // Register 0 is an ordinary register unless overridden.
  localparam int ZERO_REG_DEF = 0;

  // True when an access targets the hard-wired zero register.
  function automatic logic zero_hit(input int zero_reg, input logic addr_is_zero);
    return (zero_reg != 0) && addr_is_zero;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One registered read port: address mux, same-edge write bypass,
// zero-register force and the output data register.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int DEPTH    = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_fire_i,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Select the read value: storage, then newer write data, then zero force.
  always_comb begin
    sel_data = mem_i[ra_i];
    if (wr_fire_i && (wa_i == ra_i)) begin
      sel_data = wd_i;
    end
    if (zero_hit(ZERO_REG, ra_i == '0)) begin
      sel_data = '0;
    end
    rdata_d = rd_fire_i ? sel_data : rdata_q;
  end

  // Output register; holds its value between reads, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Two-read / one-write register file with a per-register busy scoreboard.
//
// Read handshake: rd has no ready; a read accepted at an edge (en & rd)
// updates rdata1/rdata2 at that edge and rvalid is high for exactly the
// following cycle. rdata holds its last value when no read is accepted.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              rd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  input  logic              mark,
  input  logic [ADDR_W-1:0] ma,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              rvalid_q;
  logic              rvalid_d;
  logic              wr_fire;
  logic              mark_fire;
  logic              rd_fire;

  // Qualify requests with the global enable and the zero-register rule.
  always_comb begin
    wr_fire   = en & wr & ~zero_hit(ZERO_REG, wa == '0);
    mark_fire = en & mark & ~zero_hit(ZERO_REG, ma == '0);
    rd_fire   = en & rd;
    rvalid_d  = rd_fire;
  end

  // Scoreboard next state: a write retires the producer, a mark applied
  // afterwards wins so a new producer on the same edge stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[wa] = 1'b0;
    end
    if (mark_fire) begin
      busy_d[ma] = 1'b1;
    end
  end

  // Register storage; reset clears every entry and drops a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[wa] <= wd;
    end
  end

  // Busy vector and read-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
    end
  end

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .DEPTH   (DEPTH)
  ) u_rdport1 (
    .clk      (clk),
    .rst      (rst),
    .rd_fire_i(rd_fire),
    .ra_i     (ra1),
    .wr_fire_i(wr_fire),
    .wa_i     (wa),
    .wd_i     (wd),
    .mem_i    (mem_q),
    .rdata_o  (rdata1)
  );

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .DEPTH   (DEPTH)
  ) u_rdport2 (
    .clk      (clk),
    .rst      (rst),
    .rd_fire_i(rd_fire),
    .ra_i     (ra2),
    .wr_fire_i(wr_fire),
    .wa_i     (wa),
    .wd_i     (wd),
    .mem_i    (mem_q),
    .rdata_o  (rdata2)
  );

  // Busy lookups see only registered state, never same-cycle mark/write.
  assign busy1  = busy_q[ra1];
  assign busy2  = busy_q[ra2];
  assign rvalid = rvalid_q;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with an ordinary register 0
// and one with a hard-wired zero register, driven by the same inputs.
module tb_regfile_mp;

  localparam logic [63:0] A0   = 64'h000F_0000_000F_0000;
  localparam logic [63:0] A1   = 64'hF000_0000_000F_0000;
  localparam logic [63:0] DB   = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, wr, rd, mark;
  logic [3:0]  wa, ra1, ra2, ma;
  logic [63:0] wd;

  logic [63:0] d0_rd1, d0_rd2, d1_rd1, d1_rd2;
  logic        d0_rv, d0_b1, d0_b2, d1_rv, d1_b1, d1_b2;

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wa(wa), .wd(wd), .rd(rd),
    .ra1(ra1), .ra2(ra2), .rdata1(d0_rd1), .rdata2(d0_rd2), .rvalid(d0_rv),
    .mark(mark), .ma(ma), .busy1(d0_b1), .busy2(d0_b2)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wa(wa), .wd(wd), .rd(rd),
    .ra1(ra1), .ra2(ra2), .rdata1(d1_rd1), .rdata2(d1_rd2), .rvalid(d1_rv),
    .mark(mark), .ma(ma), .busy1(d1_b1), .busy2(d1_b2)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, en, wr;
    logic [3:0]  wa;
    logic [63:0] wd;
    logic        rd;
    logic [3:0]  ra1, ra2;
    logic        mark;
    logic [3:0]  ma;
    logic [63:0] e_rd1, e_rd2;
    logic        e_rv, e_b1, e_b2;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic w,
                       input logic [3:0] a_w, input logic [63:0] d_w,
                       input logic r_d, input logic [3:0] a1,
                       input logic [3:0] a2, input logic m,
                       input logic [3:0] a_m);
    rst = r; en = e; wr = w; wa = a_w; wd = d_w; rd = r_d;
    ra1 = a1; ra2 = a2; mark = m; ma = a_m;
  endtask

  // Apply the driven inputs at one rising edge, sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] e;
    logic [63:0] sb_vals [4];

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst en wr wa wd    rd ra1 ra2 mk ma  e_rd1 e_rd2 rv b1 b2
    vecs[0]  = '{1, 1, 1, 4, 64'hAA, 1, 0, 1, 1, 2, 0,  0,  0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, A0,     0, 0, 1, 0, 0, 0,  0,  0, 0, 0};
    vecs[2]  = '{0, 1, 1, 1, A1,     0, 0, 1, 0, 0, 0,  0,  0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0,      1, 0, 1, 0, 0, A0, A1, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0,      0, 0, 1, 0, 0, A0, A1, 0, 0, 0};
    vecs[5]  = '{0, 1, 1, 5, DB,     1, 5, 0, 0, 0, DB, A0, 1, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0,      0, 3, 5, 1, 3, DB, A0, 0, 1, 0};
    vecs[7]  = '{0, 1, 1, 3, 64'h33, 0, 3, 5, 0, 0, DB, A0, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 3, 64'h44, 0, 3, 5, 1, 3, DB, A0, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0,      1, 3, 3, 0, 0, 64'h44, 64'h44, 1, 1, 1};
    vecs[10] = '{0, 0, 1, 2, 64'h1234, 1, 2, 3, 1, 2, 64'h44, 64'h44, 0, 0, 1};
    vecs[11] = '{0, 1, 0, 0, 0,      1, 2, 5, 0, 0, 0,  DB, 1, 0, 0};
    vecs[12] = '{0, 1, 1, 3, 64'h55, 1, 3, 2, 0, 0, 64'h55, 0, 1, 0, 0};

    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].wa, vecs[i].wd,
            vecs[i].rd, vecs[i].ra1, vecs[i].ra2, vecs[i].mark, vecs[i].ma);
      step();
      check($sformatf("v%0d.rdata1", i), d0_rd1, vecs[i].e_rd1);
      check($sformatf("v%0d.rdata2", i), d0_rd2, vecs[i].e_rd2);
      check($sformatf("v%0d.rvalid", i), {63'b0, d0_rv}, {63'b0, vecs[i].e_rv});
      check($sformatf("v%0d.busy1", i), {63'b0, d0_b1}, {63'b0, vecs[i].e_b1});
      check($sformatf("v%0d.busy2", i), {63'b0, d0_b2}, {63'b0, vecs[i].e_b2});
    end

    // Reset mid-sequence: mark r7 and launch a read, then reset with a
    // write, read and mark all active.
    drive(0, 1, 0, 0, 0, 1, 7, 3, 1, 7);
    step();
    check("pre_rst.busy1", {63'b0, d0_b1}, 64'd1);
    check("pre_rst.rdata2", d0_rd2, 64'h55);
    drive(1, 1, 1, 7, 64'h77, 1, 7, 3, 1, 9);
    step();
    check("rst.rdata1", d0_rd1, 64'd0);
    check("rst.rdata2", d0_rd2, 64'd0);
    check("rst.rvalid", {63'b0, d0_rv}, 64'd0);
    check("rst.busy1", {63'b0, d0_b1}, 64'd0);
    check("rst.busy2", {63'b0, d0_b2}, 64'd0);
    for (int a = 0; a < 16; a++) begin
      drive(0, 1, 0, 0, 0, 1, a[3:0], 4'(15 - a), 0, 0);
      step();
      check($sformatf("post_rst.r%0d.rdata1", a), d0_rd1, 64'd0);
      check($sformatf("post_rst.r%0d.rdata2", a), d0_rd2, 64'd0);
      check($sformatf("post_rst.r%0d.rvalid", a), {63'b0, d0_rv}, 64'd1);
      check($sformatf("post_rst.r%0d.busy", a), {62'b0, d0_b1, d0_b2}, 64'd0);
    end

    // Zero-register behaviour, compared against the ordinary instance.
    drive(0, 1, 1, 0, ONES, 0, 0, 1, 1, 0);
    step();
    check("zr.busy1", {63'b0, d1_b1}, 64'd0);
    check("nz.mark_wr_same.busy1", {63'b0, d0_b1}, 64'd1);
    drive(0, 1, 1, 0, 64'h5, 1, 0, 0, 0, 0);
    step();
    check("zr.rdata1", d1_rd1, 64'd0);
    check("zr.rdata2", d1_rd2, 64'd0);
    check("nz.r0_bypass.rdata1", d0_rd1, 64'h5);
    check("nz.r0_bypass.rdata2", d0_rd2, 64'h5);
    drive(0, 1, 1, 1, ONES, 1, 1, 0, 0, 0);
    step();
    check("zr.r1_bypass.rdata1", d1_rd1, ONES);
    check("zr.r0_after.rdata2", d1_rd2, 64'd0);
    check("nz.r0_stored.rdata2", d0_rd2, 64'h5);

    // Expected-queue sequence: fill r6..r9, read back with ra1 = ra2.
    sb_vals[0] = 64'h0123_4567_89AB_CDEF;
    sb_vals[1] = 64'h8000_0000_0000_0001;
    sb_vals[2] = 64'h5A5A_A5A5_0F0F_F0F0;
    sb_vals[3] = 64'h0000_0000_FFFF_0000;
    for (int r = 0; r < 4; r++) begin
      drive(0, 1, 1, 4'(6 + r), sb_vals[r], 0, 0, 0, 0, 0);
      step();
      exp_q.push_back(sb_vals[r]);
    end
    for (int r = 0; r < 4; r++) begin
      drive(0, 1, 0, 0, 0, 1, 4'(6 + r), 4'(6 + r), 0, 0);
      step();
      e = exp_q.pop_front();
      check($sformatf("sb.r%0d.rdata1", 6 + r), d0_rd1, e);
      check($sformatf("sb.r%0d.rdata2", 6 + r), d0_rd2, e);
      check($sformatf("sb.zr.r%0d.rdata1", 6 + r), d1_rd1, e);
      check($sformatf("sb.r%0d.rvalid", 6 + r), {63'b0, d0_rv}, 64'd1);
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes and marks.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 en  input  1  global enable; when 0, no state change except rvalid clears.
REQ-007 wr  input  1  write request.
REQ-008 wa  input  ADDR_W  write address.
REQ-009 wd  input  DATA_W  write data.
REQ-010 rd  input  1  read request for both read ports.
REQ-011 ra1, ra2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-012 rdata1, rdata2  output  DATA_W  registered read data.
REQ-013 rvalid  output  1  rdata1/rdata2 updated by a read on the previous edge.
REQ-014 mark  input  1  set the busy (pending-producer) bit of register ma.
REQ-015 ma  input  ADDR_W  mark address.
REQ-016 busy1, busy2  output  1  combinational busy bit of the register at ra1 / ra2.

Function
REQ-017 Write: en&wr at an edge stores wd into mem[wa]; suppressed when ZERO_REG=1 and wa=0.
REQ-018 Read: en&rd at an edge loads rdata1<=mem[ra1], rdata2<=mem[ra2]; latency 1 cycle.
REQ-019 Bypass: if the same edge also performs an unsuppressed write with wa=ra1 (or ra2), that port loads wd, not the old contents.
REQ-020 ZERO_REG=1: a read of address 0 returns all zeros regardless of prior writes.
REQ-021 rvalid <= en&rd each edge; rdata1/rdata2 hold their value when no read occurs.
REQ-022 ra1=ra2 is legal; both ports return identical data.
REQ-023 Scoreboard: en&mark sets busy[ma]; an unsuppressed en&wr clears busy[wa].
REQ-024 Simultaneous mark and write to the same address: busy stays set (newer producer wins).
REQ-025 ZERO_REG=1: busy[0] is never set.
REQ-026 busy1/busy2 reflect the current busy register contents; no bypass from mark or wr in the same cycle.
REQ-027 en=0: mem, busy, rdata unchanged; rvalid<=0; wr, rd, mark ignored.

Reset
REQ-028 rst at an edge clears all mem entries, all busy bits, rdata1, rdata2 and rvalid to 0.
REQ-029 rst has priority over en, wr, rd and mark in the same cycle; a write coinciding with rst is lost.
REQ-030 A read in flight when rst asserts is discarded: the next-cycle rdata = 0 and rvalid = 0.

Structure
REQ-031 Package regfile_pkg holds default DATA_W/ADDR_W constants and the ZERO_REG default.
REQ-032 One sub-module regfile_rdport (address mux, bypass compare, zero-reg force, output register), instantiated twice.
REQ-033 Storage and busy vector live in regfile_mp; no vendor RAM primitive.

Verification
REQ-034 Reset, then write 64'h000F_0000_000F_0000 to r0, 64'hF000_0000_000F_0000 to r1, read ra1=0, ra2=1 -> rdata1/rdata2 equal those values one cycle later, rvalid=1.
REQ-035 Write 64'hDEAD_BEEF_0000_0001 to r5 and read ra1=5 on the same edge -> rdata1=64'hDEAD_BEEF_0000_0001 (bypass).
REQ-036 ZERO_REG=1: write 64'hFFFF_FFFF_FFFF_FFFF to r0, read ra1=0 -> rdata1=0; mark ma=0 -> busy1=0.
REQ-037 mark ma=3 -> busy1=1 with ra1=3; write r3 -> busy1=0 next cycle; mark and write r3 same edge -> busy1 stays 1.
REQ-038 en=0 with wr=1, wa=2, wd=64'h1234 -> r2 unchanged (reads 0 after en=1), rvalid=0 during en=0.
REQ-039 Assert rst mid-sequence with wr and rd active -> all reads return 0, busy1=busy2=0, rvalid=0 after reset.
